// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus decoder.
// Window compare widens the sum so a top-of-map window never wraps.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int AW_MAX = 64;

  function automatic logic win_hit(
    input logic [AW_MAX-1:0] addr,
    input logic [AW_MAX-1:0] base,
    input logic [AW_MAX-1:0] span
  );
    logic [AW_MAX:0] lim;
    lim = {1'b0, base} + {1'b0, span};
    return (addr >= base) &&
           ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// Master-side request/response and slave-side select bundle.
// slave is the decoder view, master the driving side.
interface bus_decoder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);

  logic [ADDR_WIDTH-1:0] i_address;
  logic                  i_data_valid;
  logic                  i_wr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_resp_valid;
  logic                  o_resp_err;
  logic [DATA_WIDTH-1:0] o_data;
  logic [NUM_SLAVES-1:0] o_slave_cs;
  logic [ADDR_WIDTH-1:0] o_slave_address;
  logic                  o_slave_wr;
  logic [DATA_WIDTH-1:0] o_slave_data;
  logic [NUM_SLAVES-1:0] i_slave_ack;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_slave_data;

  modport slave (
    input  i_address, i_data_valid, i_wr,
    input  i_data, i_slave_ack, i_slave_data,
    output o_ready, o_resp_valid, o_resp_err,
    output o_data, o_slave_cs, o_slave_address,
    output o_slave_wr, o_slave_data
  );

  modport master (
    output i_address, i_data_valid, i_wr,
    output i_data, i_slave_ack, i_slave_data,
    input  o_ready, o_resp_valid, o_resp_err,
    input  o_data, o_slave_cs, o_slave_address,
    input  o_slave_wr, o_slave_data
  );

endinterface

// File: rtl/bus_decode_timer.sv
// Counts cycles spent waiting for a slave ack.
// Expired is high on the TIMEOUT-th enabled cycle.
module bus_decode_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign o_expired = i_en &&
    (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_en && !o_expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_decoder.sv
// Single-master bus decoder: latch, decode, select, await ack.
// All outputs come straight from flops.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]
    BASE_ADDRS = {NUM_SLAVES{ADDR_WIDTH'(0)}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]
    ADDR_SPANS = {NUM_SLAVES{ADDR_WIDTH'(8)}},
  parameter logic ALIGNED = 1'b1,
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  bus_decoder_if.slave bus
);

  localparam int SW =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  rv_q, rv_d;
  logic                  ready_q, ready_d;

  logic [NUM_SLAVES-1:0] hit;
  logic [SW-1:0]         hit_sel;
  logic                  addr_ok;
  logic                  expired;
  logic [DATA_WIDTH-1:0] rd_slice;

  bus_decode_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (state_q != ACCESS),
    .i_en      (state_q == ACCESS),
    .o_expired (expired)
  );

  assign rd_slice = bus.i_slave_data[
    int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

  // Lowest index wins when windows overlap.
  always_comb begin
    addr_ok = !ALIGNED ||
      (bus.i_address[1:0] == 2'b00);
    hit     = '0;
    hit_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      hit[i] = addr_ok && win_hit(
        AW_MAX'(bus.i_address),
        AW_MAX'(BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]),
        AW_MAX'(ADDR_SPANS[i*ADDR_WIDTH +: ADDR_WIDTH]));
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (hit[i]) hit_sel = SW'(i);
  end

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdat_d  = wdat_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_data_valid) begin
          addr_d = bus.i_address;
          wr_d   = bus.i_wr;
          wdat_d = bus.i_data;
          data_d = '0;
          if (|hit) begin
            sel_d   = hit_sel;
            cs_d    = NUM_SLAVES'(1) << hit_sel;
            err_d   = RESP_OK;
            state_d = ACCESS;
          end else begin
            err_d   = RESP_ERR;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (bus.i_slave_ack[sel_q]) begin
          cs_d    = '0;
          data_d  = wr_q ? '0 : rd_slice;
          err_d   = RESP_OK;
          state_d = RESP;
        end else if (expired) begin
          cs_d    = '0;
          data_d  = '0;
          err_d   = RESP_ERR;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    rv_d    = (state_d == RESP);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cs_q    <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_ready         = ready_q;
  assign bus.o_resp_valid    = rv_q;
  assign bus.o_resp_err      = err_q;
  assign bus.o_data          = data_q;
  assign bus.o_slave_cs      = cs_q;
  assign bus.o_slave_address = addr_q;
  assign bus.o_slave_wr      = wr_q;
  assign bus.o_slave_data    = wdat_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized scoreboard bench for bus_decoder.
// dut_a checks alignment; dut_b does not and times out sooner.
module tb_bus_decoder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO_A = 16;
  localparam int TO_B = 4;
  localparam logic [NS*AW-1:0] BASES =
    {32'hFFFF_FFF8, 32'h0, 32'h100, 32'h0};
  localparam logic [NS*AW-1:0] SPANS =
    {32'h8, 32'h200, 32'h10, 32'h40};

  longint wbase [NS] = '{0, 'h100, 0, 'hFFFF_FFF8};
  longint wspan [NS] = '{'h40, 'h10, 'h200, 8};

  typedef struct packed {
    int          tgt;
    logic        err;
    logic [DW-1:0] data;
    int          cs_cyc;
    logic [AW-1:0] addr;
    logic        wr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] addr;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          va, vb;
  logic [NS-1:0] ack;
  logic [NS*DW-1:0] sdata;

  bus_decoder_if #(.ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .NUM_SLAVES(NS)) ifa ();
  bus_decoder_if #(.ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .NUM_SLAVES(NS)) ifb ();

  assign ifa.i_address    = addr;
  assign ifa.i_wr         = wr;
  assign ifa.i_data       = wdata;
  assign ifa.i_data_valid = va;
  assign ifa.i_slave_ack  = ack;
  assign ifa.i_slave_data = sdata;
  assign ifb.i_address    = addr;
  assign ifb.i_wr         = wr;
  assign ifb.i_data       = wdata;
  assign ifb.i_data_valid = vb;
  assign ifb.i_slave_ack  = ack;
  assign ifb.i_slave_data = sdata;

  bus_decoder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_SLAVES(NS), .BASE_ADDRS(BASES),
    .ADDR_SPANS(SPANS), .ALIGNED(1'b1),
    .TIMEOUT(TO_A)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa)
  );

  bus_decoder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_SLAVES(NS), .BASE_ADDRS(BASES),
    .ADDR_SPANS(SPANS), .ALIGNED(1'b0),
    .TIMEOUT(TO_B)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int busy [2] = '{0, 0};
  int lat  [2] = '{0, 0};
  int csc  [2] = '{0, 0};
  logic done = 1'b0;
  logic fin  = 1'b0;

  function automatic int model_tgt(
    input int d, input logic [AW-1:0] a);
    if (d == 0 && (a % 4) != 0) return -1;
    for (int i = 0; i < NS; i++)
      if (longint'(a) >= wbase[i] &&
          longint'(a) < wbase[i] + wspan[i])
        return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int d,
    input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h",
        nm, d, act, req);
    end
  endtask

  task automatic pop(input int d);
    if (d == 1) void'(qb.pop_front());
    else        void'(qa.pop_front());
    busy[d] = 0;
  endtask

  task automatic mon(input int d,
    input logic rdy, input logic rv, input logic er,
    input logic [DW-1:0] od, input logic [NS-1:0] cs,
    input logic [AW-1:0] sa, input logic sw,
    input logic [DW-1:0] sd, input logic vld);
    exp_t e;
    int   qs;
    if (rst) begin
      chk("rst_cs", d, cs, 0);
      chk("rst_ready", d, rdy, 1);
      chk("rst_resp_valid", d, rv, 0);
      chk("rst_err", d, er, 0);
      chk("rst_data", d, od, 0);
      chk("rst_slave_addr", d, sa, 0);
      chk("rst_slave_wr", d, sw, 0);
      chk("rst_slave_data", d, sd, 0);
      busy[d] = 0;
      if (d == 1) qb.delete();
      else        qa.delete();
      return;
    end
    qs = (d == 1) ? qb.size() : qa.size();
    if (busy[d] != 0 && qs > 0) begin
      e = (d == 1) ? qb[0] : qa[0];
      lat[d]++;
      if (cs != 0) begin
        csc[d]++;
        chk("cs_onehot", d, cs,
          (e.tgt < 0) ? 0 : (1 << e.tgt));
        chk("slave_addr", d, sa, e.addr);
        chk("slave_wr", d, sw, e.wr);
        chk("slave_data", d, sd, e.wdata);
      end
      if (rv) begin
        chk("resp_err", d, er, e.err);
        chk("resp_data", d, od, e.data);
        chk("cs_cycles", d, csc[d], e.cs_cyc);
        chk("latency", d, lat[d], e.cs_cyc + 1);
        pop(d);
      end else if (lat[d] > 60) begin
        chk("resp_timeout", d, rv, 1);
        pop(d);
      end
    end else begin
      if (rv) chk("stray_resp", d, rv, 0);
      if (cs != 0) chk("idle_cs", d, cs, 0);
    end
    if (vld && rdy) begin
      busy[d] = 1;
      lat[d]  = 0;
      csc[d]  = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.o_ready, ifa.o_resp_valid,
      ifa.o_resp_err, ifa.o_data, ifa.o_slave_cs,
      ifa.o_slave_address, ifa.o_slave_wr,
      ifa.o_slave_data, va);
    mon(1, ifb.o_ready, ifb.o_resp_valid,
      ifb.o_resp_err, ifb.o_data, ifb.o_slave_cs,
      ifb.o_slave_address, ifb.o_slave_wr,
      ifb.o_slave_data, vb);
    if (done && !fin) begin
      chk("pending_a", 0, qa.size(), 0);
      chk("pending_b", 1, qb.size(), 0);
      fin = 1'b1;
    end
  end

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((d == 1) ? ifb.o_ready : ifa.o_ready)
               && n < 100);
    if (n >= 100) begin
      $display("FAIL ready_wait dut=%0d actual=0 required=1", d);
      $fatal(1, "ready never returned");
    end
  endtask

  task automatic txn(input int d, input logic [AW-1:0] a,
    input logic w, input int k, input logic [DW-1:0] rd);
    exp_t e;
    int   to, n;
    to       = (d == 1) ? TO_B : TO_A;
    e.tgt    = model_tgt(d, a);
    e.addr   = a;
    e.wr     = w;
    e.wdata  = $urandom;
    if (e.tgt < 0) begin
      e.err = 1'b1; e.data = '0; e.cs_cyc = 0;
    end else if (k <= to) begin
      e.err = 1'b0; e.data = w ? '0 : rd; e.cs_cyc = k;
    end else begin
      e.err = 1'b1; e.data = '0; e.cs_cyc = to;
    end
    if (d == 1) qb.push_back(e);
    else        qa.push_back(e);
    addr  = a;
    wr    = w;
    wdata = e.wdata;
    if (d == 1) vb = 1'b1;
    else        va = 1'b1;
    wait_ready(d);
    @(posedge clk); #1;
    va = 1'b0;
    vb = 1'b0;
    n = e.cs_cyc;
    for (int j = 1; j <= n; j++) begin
      ack   = NS'($urandom) & ~(NS'(1) << e.tgt);
      sdata = {$urandom, $urandom, $urandom, $urandom};
      if (j == k) begin
        ack = ack | (NS'(1) << e.tgt);
        sdata[e.tgt*DW +: DW] = rd;
      end
      @(posedge clk); #1;
    end
    ack = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    unique case ($urandom_range(0, 4))
      0: return AW'($urandom_range(0, 'h4f));
      1: return AW'('h100 + $urandom_range(0, 'h1f));
      2: return AW'($urandom_range('h1f0, 'h210));
      3: return 32'hFFFF_FFF0 + AW'($urandom_range(0, 15));
      default: return AW'($urandom);
    endcase
  endfunction

  // Request to slave 0, then reset two cycles into the wait.
  task automatic reset_mid_access();
    exp_t e;
    e = '{tgt: 0, err: 1'b0, data: '0, cs_cyc: 0,
          addr: '0, wr: 1'b0, wdata: '0};
    qa.push_back(e);
    addr = '0; wr = 1'b0; wdata = '0;
    va = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    va = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int d, to;
    addr = '0; wr = 1'b0; wdata = '0;
    va = 1'b0; vb = 1'b0; ack = '0; sdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    txn(0, 32'h104, 1'b0, 3, 32'hDEAD_BEEF);
    txn(0, 32'h8000, 1'b0, 1, $urandom);
    txn(0, 32'h102, 1'b1, 1, $urandom);
    txn(1, 32'h102, 1'b1, 2, $urandom);
    txn(0, 32'h0, 1'b0, 99, $urandom);
    txn(0, 32'h0, 1'b0, 16, $urandom);
    txn(0, 32'h0, 1'b0, 1, $urandom);
    txn(0, 32'h200, 1'b0, 1, $urandom);
    txn(0, 32'h10C, 1'b0, 2, $urandom);
    txn(0, 32'h110, 1'b0, 2, $urandom);
    txn(0, 32'hFFFF_FFFC, 1'b0, 2, $urandom);
    txn(0, 32'hFFFF_FFF4, 1'b0, 2, $urandom);
    txn(1, 32'h103, 1'b0, 9, $urandom);
    reset_mid_access();
    txn(0, 32'h104, 1'b0, 1, $urandom);
    for (int i = 0; i < 300; i++) begin
      d  = $urandom_range(0, 1);
      to = (d == 1) ? TO_B : TO_A;
      txn(d, rnd_addr(), 1'($urandom_range(0, 1)),
        $urandom_range(1, to + 3), $urandom);
    end
    repeat (30) @(posedge clk);
    done = 1'b1;
    for (int i = 0; i < 10 && !fin; i++)
      @(posedge clk);
    if (!fin)
      $display("FAIL final_check actual=0 required=1");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad + (fin ? 0 : 1));
    $finish;
  end

endmodule
